// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: issue, multdiv-unit and writeback signals
// slave = sequencer side, master = pipeline/unit side
interface multdiv_sequencer_if;
  logic        is_mul;
  logic        is_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;

  modport slave (
    input  is_mul, is_div,
    input  operand_a, operand_b, dest_reg,
    input  md_result, md_exception, md_ready,
    output md_ctrl_mult, md_ctrl_div,
    output md_operand_a, md_operand_b,
    output stall, busy,
    output wb_valid, wb_data, wb_reg
  );

  modport master (
    output is_mul, is_div,
    output operand_a, operand_b, dest_reg,
    output md_result, md_exception, md_ready,
    input  md_ctrl_mult, md_ctrl_div,
    input  md_operand_a, md_operand_b,
    input  stall, busy,
    input  wb_valid, wb_data, wb_reg
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mul/div to the shared unit, stalls, writes back
// MD_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic clock,
  input logic reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [4:0]  RSTATUS = 5'd30;
  localparam logic [31:0] EXC_MUL = 32'd4;
  localparam logic [31:0] EXC_DIV = 32'd5;

  state_t      r_state;
  state_t      w_next;

  logic        r_op_mul;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_dest;
  logic [31:0] r_result;
  logic        r_exc;

  logic        w_can_issue;
  logic        w_issue;
  logic        w_done;
  logic        w_timeout;

  assign w_can_issue = (r_state == S_IDLE) ||
                       (r_state == S_WB);
  assign w_issue = w_can_issue &&
                   (bus.is_mul || bus.is_div);
  assign w_done = (r_state == S_WAIT) && bus.md_ready;

`ifdef MD_TIMEOUT_EN
  localparam int CW0 = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CW0 > 6) ? CW0 : 6;

  logic [CW-1:0] r_wait_cnt;

  // count WAIT cycles; cleared in START so each WAIT entry restarts it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_START) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  // a ready pulse in the expiry cycle takes priority
  assign w_timeout = (r_state == S_WAIT) &&
                     !bus.md_ready &&
                     (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) w_next = S_START;
      end
      S_START: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done || w_timeout) w_next = S_WB;
      end
      S_WB: begin
        if (w_issue) w_next = S_START;
        else         w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // issue latch: operands, dest and op type; mul wins over div
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_mul <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_dest   <= '0;
    end else if (w_issue) begin
      r_op_mul <= bus.is_mul;
      r_op_a   <= bus.operand_a;
      r_op_b   <= bus.operand_b;
      r_dest   <= bus.dest_reg;
    end
  end

  // completion latch: unit result/flag, or forced exception on timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_done) begin
      r_result <= bus.md_result;
      r_exc    <= bus.md_exception;
    end else if (w_timeout) begin
      r_result <= '0;
      r_exc    <= 1'b1;
    end
  end

  // outputs decoded from state and latched registers
  always_comb begin
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.busy         = (r_state != S_IDLE);
    bus.wb_valid     = 1'b0;
    bus.wb_data      = '0;
    bus.wb_reg       = '0;
    if (r_state == S_START) begin
      bus.md_ctrl_mult = r_op_mul;
      bus.md_ctrl_div  = !r_op_mul;
    end
    if (r_state == S_WB) begin
      if (r_exc) begin
        bus.wb_valid = 1'b1;
        bus.wb_reg   = RSTATUS;
        bus.wb_data  = r_op_mul ? EXC_MUL : EXC_DIV;
      end else begin
        bus.wb_valid = (r_dest != 5'd0);
        bus.wb_reg   = r_dest;
        bus.wb_data  = r_result;
      end
    end
  end

  assign bus.md_operand_a = r_op_a;
  assign bus.md_operand_b = r_op_b;

  // only the IDLE-issue term is combinational; WB issue does not stall
  assign bus.stall = ((r_state == S_IDLE) && w_issue) ||
                     (r_state == S_START) ||
                     (r_state == S_WAIT);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: table vectors, scoreboard and corner sequences
// builds with or without MD_TIMEOUT_EN
module tb_multdiv_sequencer;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  multdiv_sequencer_if bus ();

  multdiv_sequencer #(
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  typedef struct {
    logic        m;
    logic        dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ovf;
    int          dly;
    logic        ev;
    logic [4:0]  er;
    logic [31:0] ed;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int n_mul, n_div, n_wb, n_stall;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.md_ctrl_mult) n_mul++;
      if (bus.md_ctrl_div)  n_div++;
      if (bus.wb_valid)     n_wb++;
      if (bus.stall)        n_stall++;
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_mul = 0;
    n_div = 0;
    n_wb = 0;
    n_stall = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_chk(string tag);
    wb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got wb_valid %0b",
               tag, bus.wb_valid);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'(e.v));
      chk({tag, "_wb_reg"}, 32'(bus.wb_reg), 32'(e.r));
      chk({tag, "_wb_data"}, bus.wb_data, e.d);
    end
  endtask

  function automatic logic [31:0] unit_res(vec_t v);
    if (v.m) return v.a * v.b;
    if (v.b == 0) return 32'hDEAD_BEEF;
    return v.a / v.b;
  endfunction

  function automatic logic unit_exc(vec_t v);
    return v.ovf || (!v.m && v.b == 0);
  endfunction

  task automatic idle_inputs();
    bus.is_mul = 1'b0;
    bus.is_div = 1'b0;
    bus.md_ready = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result = '0;
  endtask

  task automatic issue(logic m, logic dv, logic [31:0] a,
                       logic [31:0] b, logic [4:0] rd);
    bus.is_mul = m;
    bus.is_div = dv;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg = rd;
  endtask

  task automatic ready_pulse(logic [31:0] res, logic exc);
    bus.md_ready = 1'b1;
    bus.md_result = res;
    bus.md_exception = exc;
    tick();
    bus.md_ready = 1'b0;
    bus.md_exception = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 0);
    chk({tag, "_wb_reg"}, 32'(bus.wb_reg), 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_ctrl_mult"}, 32'(bus.md_ctrl_mult), 0);
    chk({tag, "_ctrl_div"}, 32'(bus.md_ctrl_div), 0);
    chk({tag, "_op_a"}, bus.md_operand_a, 0);
    chk({tag, "_op_b"}, bus.md_operand_b, 0);
  endtask

  task automatic run_vec(vec_t v, string tag);
    wb_t e;
    clr_mon();
    issue(v.m, v.dv, v.a, v.b, v.rd);
    #1;
    chk({tag, "_issue_stall"}, 32'(bus.stall), 1);
    chk({tag, "_issue_busy"}, 32'(bus.busy), 0);
    e = '{v: v.ev, r: v.er, d: v.ed};
    sb.push_back(e);
    tick();
    issue(1'b0, 1'b0, 32'h5555_5555, 32'hAAAA_AAAA, 5'd17);
    chk({tag, "_op_a"}, bus.md_operand_a, v.a);
    chk({tag, "_op_b"}, bus.md_operand_b, v.b);
    tick();
    for (int k = 1; k < v.dly; k++) tick();
    chk({tag, "_wait_stall"}, 32'(bus.stall), 1);
    ready_pulse(unit_res(v), unit_exc(v));
    chk({tag, "_wb_stall"}, 32'(bus.stall), 0);
    pop_chk(tag);
    tick();
    chk({tag, "_end_busy"}, 32'(bus.busy), 0);
    chk({tag, "_n_mul"}, n_mul, v.m ? 1 : 0);
    chk({tag, "_n_div"}, n_div, (!v.m && v.dv) ? 1 : 0);
    chk({tag, "_n_stall"}, n_stall, 2 + v.dly);
    chk({tag, "_n_wb"}, n_wb, v.ev ? 1 : 0);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{1, 0, 7, 6, 5, 0, 10, 1, 5, 42};
    vecs[1] = '{0, 1, 100, 0, 8, 0, 3, 1, 30, 5};
    vecs[2] = '{1, 1, 3, 4, 9, 1, 1, 1, 30, 4};
    vecs[3] = '{0, 1, 100, 7, 12, 0, 2, 1, 12, 14};
    vecs[4] = '{1, 0, 5, 5, 0, 0, 1, 0, 0, 25};
    vecs[5] = '{0, 1, 9, 0, 0, 0, 2, 1, 30, 5};
    vecs[6] = '{1, 0, 32'h1_0000, 32'h1_0000, 31, 0, 4,
                1, 31, 0};
    vecs[7] = '{0, 1, 32'hFFFF_FFFF, 16, 1, 0, 5,
                1, 1, 32'h0FFF_FFFF};

    reset = 1'b1;
    idle_inputs();
    issue(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_zero("reset");
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ready during START must be ignored
    clr_mon();
    issue(1'b1, 1'b0, 2, 2, 4);
    sb.push_back('{v: 1'b1, r: 5'd4, d: 32'd4});
    tick();
    issue(1'b0, 1'b0, 0, 0, 0);
    bus.md_ready = 1'b1;
    bus.md_result = 32'd99;
    tick();
    bus.md_ready = 1'b0;
    chk("start_rdy_busy", 32'(bus.busy), 1);
    chk("start_rdy_stall", 32'(bus.stall), 1);
    chk("start_rdy_wbv", 32'(bus.wb_valid), 0);
    tick();
    ready_pulse(32'd4, 1'b0);
    pop_chk("start_rdy");
    tick();

    // div issued in the WB cycle of a mul
    clr_mon();
    issue(1'b1, 1'b0, 3, 3, 2);
    sb.push_back('{v: 1'b1, r: 5'd2, d: 32'd9});
    tick();
    issue(1'b0, 1'b0, 0, 0, 0);
    tick();
    ready_pulse(32'd9, 1'b0);
    issue(1'b0, 1'b1, 50, 5, 3);
    #1;
    chk("b2b_wb_stall", 32'(bus.stall), 0);
    pop_chk("b2b_mul");
    sb.push_back('{v: 1'b1, r: 5'd3, d: 32'd10});
    tick();
    issue(1'b0, 1'b0, 0, 0, 0);
    chk("b2b_start_busy", 32'(bus.busy), 1);
    chk("b2b_start_div", 32'(bus.md_ctrl_div), 1);
    chk("b2b_op_a", bus.md_operand_a, 50);
    tick();
    ready_pulse(32'd10, 1'b0);
    pop_chk("b2b_div");
    tick();
    chk("b2b_n_mul", n_mul, 1);
    chk("b2b_n_div", n_div, 1);
    chk("b2b_n_wb", n_wb, 2);

    // reset in WAIT, then a late ready
    issue(1'b1, 1'b0, 11, 12, 7);
    tick();
    issue(1'b0, 1'b0, 0, 0, 0);
    tick();
    tick();
    clr_mon();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready_pulse(32'd132, 1'b0);
    check_zero("rst_wait");
    tick();
    tick();
    chk("rst_wait_n_wb", n_wb, 0);
    chk("rst_wait_n_mul", n_mul, 0);
    chk("rst_wait_busy2", 32'(bus.busy), 0);

    // unit never answers
    clr_mon();
    issue(1'b1, 1'b0, 6, 7, 6);
    tick();
    issue(1'b0, 1'b0, 0, 0, 0);
    cyc = 0;
    while (!bus.wb_valid && cyc < 60) begin
      tick();
      cyc++;
    end
`ifdef MD_TIMEOUT_EN
    sb.push_back('{v: 1'b1, r: 5'd30, d: 32'd4});
    chk("timeout_cycles", cyc, 41);
    pop_chk("timeout");
    tick();
    chk("timeout_idle", 32'(bus.busy), 0);
`else
    chk("no_timeout_stall", 32'(bus.stall), 1);
    chk("no_timeout_busy", 32'(bus.busy), 1);
    chk("no_timeout_n_wb", n_wb, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("no_timeout_rst", 32'(bus.busy), 0);
`endif

    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the shared multi-cycle multiply/divide unit for the five-stage pipeline. The block latches a mult/div instruction issued from execute and pulses the unit's start control. It stalls the pipeline until the unit reports ready, then presents a single writeback beat. On an arithmetic exception it redirects that writeback to $rstatus (r30) with the status code.

## Interface
- `TIMEOUT_CYCLES`, default 40: watchdog limit in WAIT cycles; used only when `MD_TIMEOUT_EN` is defined.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `is_mul` in 1: execute stage holds a mul instruction (issue request).
- `is_div` in 1: execute stage holds a div instruction (issue request).
- `operand_a` in 32: rs value.
- `operand_b` in 32: rt value.
- `dest_reg` in 5: rd of the issuing instruction.
- `md_result` in 32: multdiv unit result.
- `md_exception` in 1: multdiv unit overflow/divide-by-zero flag, valid with `md_ready`.
- `md_ready` in 1: multdiv unit result-ready, one-cycle pulse.
- `md_ctrl_mult` out 1: one-cycle start pulse to the unit.
- `md_ctrl_div` out 1: one-cycle start pulse to the unit.
- `md_operand_a` out 32: latched operand, held stable from START through WAIT.
- `md_operand_b` out 32: latched operand, held stable from START through WAIT.
- `stall` out 1: freeze PC, F/D and D/X latches.
- `busy` out 1: state is not IDLE.
- `wb_valid` out 1: writeback beat.
- `wb_data` out 32: writeback value.
- `wb_reg` out 5: writeback register.

## Operation
- States: IDLE, START, WAIT, WB.
- Issue is accepted in IDLE or WB when `is_mul | is_div`.
  - Both requests high: treated as mul; div is ignored.
  - On issue, latch the operands, `dest_reg` and the op type (mul/div), then go to START.
- START:
  - Assert `md_ctrl_mult` or `md_ctrl_div` for exactly one cycle, per the latched op.
  - Go to WAIT.
- WAIT:
  - On `md_ready`, latch `md_result` and `md_exception`, then go to WB.
  - `md_ready` seen in START is ignored.
- WB, no exception:
  - `wb_reg` = latched dest.
  - `wb_data` = latched result.
  - `wb_valid` = 1, except when dest = 0, where `wb_valid` = 0.
- WB, exception:
  - `wb_reg` = 30.
  - `wb_data` = 4 for mul, 5 for div.
  - `wb_valid` = 1 regardless of dest.
- WB → IDLE, or WB → START if a new issue arrives in the WB cycle.
- `stall` = (issue in IDLE) | START | WAIT. `stall` is low in WB.
- `busy` = state ≠ IDLE.
- Reset:
  - All outputs and latched registers go to 0; state goes to IDLE.
  - Reset mid-operation abandons the operation with no writeback and no further ctrl pulses.
  - A late `md_ready` arriving after reset is ignored.

## Timing
- Cycle 0: issue seen; `stall` = 1 combinationally.
- Cycle 1: START; ctrl pulse high.
- Cycle 2 onward: WAIT.
- Cycle after `md_ready`: WB; `wb_valid` high for exactly one cycle.
- Minimum latency, issue to `wb_valid`: 3 cycles (when `md_ready` arrives in the first WAIT cycle).
- Latency otherwise: 2 + (WAIT cycles until `md_ready`) + 1.
- `md_operand_a`/`md_operand_b` change only on an issue edge.
- All outputs except `stall` are registered or decoded from state only.

## Configuration
- `MD_TIMEOUT_EN` defined:
  - A WAIT-cycle counter (6 bits minimum) resets on entering WAIT.
  - If the counter reaches `TIMEOUT_CYCLES` without `md_ready`, force WB with exception: r30 ← 4 for mul, 5 for div.
  - `md_ready` arriving in the same cycle as the timeout wins, giving normal completion.
- `MD_TIMEOUT_EN` undefined:
  - No counter.
  - WAIT holds indefinitely until `md_ready` or `reset`.

## Test plan
- mul 7×6, dest 5, `md_ready` 10 cycles after START: one `md_ctrl_mult` pulse, `stall` high 12 cycles, then `wb_valid` with reg 5 / data 42, `stall` low.
- div 100/0, dest 8, unit returns `md_exception`=1: WB gives reg 30 / data 5; no write to r8.
- `is_mul` and `is_div` both high: only `md_ctrl_mult` pulses; an overflow exception writes data 4 to r30.
- Back-to-back: a new div issued during the WB cycle of a mul: mul writeback occurs, then START follows immediately with no IDLE cycle.
- `reset` asserted in WAIT, then `md_ready` pulses: outputs 0, state IDLE, no `wb_valid`.
- `MD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=40, `md_ready` never asserted: WB after 40 WAIT cycles, r30 ← 4 for mul. Without the macro, `stall` remains high.
